// File: rtl/comb_sweep_pkg.sv
// comb_sweep_pkg: shared types and sizes for the mux-circuit sweeper.
// Imported by comb_golden and comb_circ_sweeper.
package comb_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int NUM_VEC = 8;
   localparam int IDX_W   = 3;
   localparam int ERR_W   = 4;
   localparam int CNT_W   = 4;

endpackage

// File: rtl/comb_circ_sweeper_if.sv
// comb_circ_sweeper_if: control, status and circuit-side signals.
// slave = sweeper side, master = controller / circuit side.
interface comb_circ_sweeper_if;
   import comb_sweep_pkg::*;

   logic             start;
   logic             dut_a;
   logic             dut_b;
   logic             dut_c;
   logic             dut_x;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [IDX_W-1:0] first_fail;

   modport slave (
      input  start, dut_x,
      output dut_a, dut_b, dut_c,
      output busy, done, pass, err_count, first_fail
   );

   modport master (
      output start, dut_x,
      input  dut_a, dut_b, dut_c,
      input  busy, done, pass, err_count, first_fail
   );

endinterface

// File: rtl/comb_golden.sv
// comb_golden: reference model of X = B ? A : C for vector {A,B,C}.
// Purely combinational.
module comb_golden
   import comb_sweep_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic             expected
);

   assign expected = idx[1] ? idx[2] : idx[0];

endmodule

// File: rtl/comb_circ_sweeper.sv
// comb_circ_sweeper: sweeps all {A,B,C} vectors and checks X.
// Option: COMB_SWEEP_STOP_ON_FAIL_EN ends the sweep on first mismatch.
module comb_circ_sweeper
   import comb_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst,
   comb_circ_sweeper_if.slave  bus
);

`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic             busy, busy_n;
   logic             done, done_n;
   logic             pass, pass_n;
   logic [ERR_W-1:0] err, err_n;
   logic [IDX_W-1:0] ff, ff_n;
   logic             expected;
   logic             mismatch;
   logic             last;

   comb_golden u_golden (
      .idx      (idx),
      .expected (expected)
   );

   assign mismatch = bus.dut_x != expected;
   assign last     = (idx == IDX_LAST) || (STOP_ON_FAIL && mismatch);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      busy_n  = busy;
      done_n  = 1'b0;
      pass_n  = pass;
      err_n   = err;
      ff_n    = ff;
      unique case (state)
         IDLE: begin
            idx_n  = '0;
            busy_n = 1'b0;
            if (bus.start) begin
               err_n   = '0;
               pass_n  = 1'b0;
               ff_n    = '0;
               cnt_n   = '0;
               busy_n  = 1'b1;
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == CNT_LAST) begin
               state_n = SAMPLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         SAMPLE: begin
            if (mismatch) begin
               if (err != ERR_MAX) err_n = err + 1'b1;
               if (err == '0)      ff_n  = idx;
            end
            if (last) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = DONE;
            end else begin
               idx_n   = idx + 1'b1;
               cnt_n   = '0;
               state_n = SETTLE;
            end
         end
         DONE: begin
            pass_n  = (err == '0);
            idx_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
         err   <= '0;
         ff    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         busy  <= busy_n;
         done  <= done_n;
         pass  <= pass_n;
         err   <= err_n;
         ff    <= ff_n;
      end
   end

   assign bus.dut_a      = idx[2];
   assign bus.dut_b      = idx[1];
   assign bus.dut_c      = idx[0];
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.pass       = pass;
   assign bus.err_count  = err;
   assign bus.first_fail = ff;

endmodule

// File: tb/tb_comb_circ_sweeper.sv
// tb_comb_circ_sweeper: directed checks of the mux-circuit sweeper.
// Circuit model: X = B ? A : C with 15 ns delay, or forced faults.
module tb_comb_circ_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic x_good = 1'b0;
   int   mode = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   done_cnt = 0;
   int   busy0;
   int   vec4;

   comb_circ_sweeper_if bus();

   comb_circ_sweeper #(.SETTLE_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(bus.dut_a or bus.dut_b or bus.dut_c)
      x_good <= #15 (bus.dut_b ? bus.dut_a : bus.dut_c);

   always_comb begin
      if (mode == 1)
         bus.dut_x = 1'b0;
      else if (mode == 2)
         bus.dut_x = ~(bus.dut_b ? bus.dut_a : bus.dut_c);
      else
         bus.dut_x = x_good;
   end

   always @(negedge clk)
      if (bus.done) done_cnt++;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic run_sweep(input int mid, input bit hold, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (k == 0) begin
            busy0 = int'(bus.busy);
            if (!hold) bus.start = 1'b0;
         end
         if (k == 4) vec4 = int'({bus.dut_a, bus.dut_b, bus.dut_c});
         if (k == mid) bus.start = 1'b1;
         if (k == mid + 1) bus.start = 1'b0;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_result(input string t, input int e_err,
                               input int e_ff, input int e_pass);
      @(posedge clk);
      @(negedge clk);
      chk({t, "_pass"}, int'(bus.pass), e_pass);
      chk({t, "_err"}, int'(bus.err_count), e_err);
      chk({t, "_ff"}, int'(bus.first_fail), e_ff);
      chk({t, "_busy"}, int'(bus.busy), 0);
      chk({t, "_done"}, int'(bus.done), 0);
   endtask

   int lat;
   int lat2;
   int d0;

   initial begin
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_abc", int'({bus.dut_a, bus.dut_b, bus.dut_c}), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pass", int'(bus.pass), 0);
      chk("rst_err", int'(bus.err_count), 0);
      chk("rst_ff", int'(bus.first_fail), 0);
      rst = 1'b0;

      mode = 0;
      run_sweep(-5, 1'b0, lat);
      chk("good_lat", lat, 32);
      chk("good_busy0", busy0, 1);
      chk("good_vec4", vec4, 1);
      check_result("good", 0, 0, 1);

      mode = 1;
      run_sweep(-5, 1'b0, lat);
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
      chk("stuck_lat", lat, 8);
      check_result("stuck", 1, 1, 0);
`else
      chk("stuck_lat", lat, 32);
      check_result("stuck", 4, 1, 0);
`endif

      mode = 2;
      run_sweep(-5, 1'b0, lat);
`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
      chk("inv_lat", lat, 4);
      check_result("inv", 1, 0, 0);
`else
      chk("inv_lat", lat, 32);
      check_result("inv", 8, 0, 0);
`endif

      mode = 0;
      d0 = done_cnt;
      run_sweep(10, 1'b0, lat);
      chk("mid_lat", lat, 32);
      repeat (40) @(negedge clk);
      chk("mid_dones", done_cnt - d0, 1);
      chk("mid_pass", int'(bus.pass), 1);

      run_sweep(-5, 1'b1, lat);
      chk("hold_lat", lat, 32);
      @(negedge clk);
      chk("hold_gap_busy", int'(bus.busy), 0);
      chk("hold_gap_done", int'(bus.done), 0);
      @(negedge clk);
      chk("hold_restart_busy", int'(bus.busy), 1);
      lat2 = -1;
      for (int k = 0; k < 200; k++) begin
         if (bus.done) begin
            lat2 = k;
            break;
         end
         @(negedge clk);
      end
      chk("hold_lat2", lat2, 32);
      bus.start = 1'b0;
      check_result("hold", 0, 0, 1);

`ifdef COMB_SWEEP_STOP_ON_FAIL_EN
      mode = 0;
`else
      mode = 1;
`endif
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         if (k == 0) bus.start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("ar_abc", int'({bus.dut_a, bus.dut_b, bus.dut_c}), 0);
      chk("ar_busy", int'(bus.busy), 0);
      chk("ar_err", int'(bus.err_count), 0);
      chk("ar_done", int'(bus.done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("ar_no_done", done_cnt - d0, 0);
      mode = 0;
      run_sweep(-5, 1'b0, lat);
      chk("ar_lat", lat, 32);
      check_result("ar", 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
